display_scan_driver: RTL and testbench

Multiplexed 7-segment driver for the Nexys-4 8-digit display, consuming the 16-bit test value and 4 dot switches produced by the display test harness. It time-multiplexes four hex digits onto the right-hand four display positions and holds the left four dark. Its active-low digit and segment outputs drive the board pins directly. Value and dots are captured once per scan frame, so a digit never changes partway through a frame.

---
 rtl/display_pkg.sv | 21 ++
 rtl/display_scan_driver_if.sv | 10 +
 rtl/display_scan_driver_hex_to_seg.sv | 13 +
 rtl/display_scan_driver.sv | 78 +++++++
 tb/tb_display_scan_driver.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
package display_pkg;

  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [7:0]  DIGIT_OFF = 8'hFF;
  localparam int unsigned NUM_SCAN  = 4;

  // Active-low {a..g} glyphs; entry 0 is the rightmost slice, entry 15 the leftmost
  localparam logic [15:0][6:0] GLYPH = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_e;

endpackage

// File: rtl/display_scan_driver_if.sv
// Value/dot inputs and active-low pin outputs of the scan driver.
interface display_scan_driver_if;
  logic [15:0] dispVal;
  logic [3:0]  swit;
  logic [7:0]  digit;
  logic [7:0]  segment;

  modport master (output dispVal, output swit, input digit, input segment);
  modport slave  (input dispVal, input swit, output digit, output segment);
endinterface

// File: rtl/display_scan_driver_hex_to_seg.sv
// Nibble to active-low 7-segment glyph lookup.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = GLYPH[i_nib];
  end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexes four hex digits onto the right half of an 8-digit display,
// with a dark interval at the start of every slot and once-per-frame capture.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 5000,
  parameter int unsigned BLANK_CYCLES = 250
) (
  input  logic                   clk5,
  input  logic                   reset,
  display_scan_driver_if.slave   disp
);

  localparam int unsigned   CW        = $clog2(REFRESH_DIV);
  localparam int unsigned   IW        = $clog2(NUM_SCAN);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_SCAN - 1);

  logic [CW-1:0] r_slotCnt;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_frameVal;
  logic [3:0]    r_frameDot;
  logic [7:0]    r_digit;
  logic [7:0]    r_segment;

  phase_e        w_phase;
  logic [3:0]    w_nib;
  logic [6:0]    w_glyph;
  logic [7:0]    w_digitOn;

  always_comb begin
    w_phase   = (r_slotCnt < BLANK_END) ? PH_BLANK : PH_DRIVE;
    w_nib     = r_frameVal[{r_idx, 2'b00} +: 4];
    w_digitOn = DIGIT_OFF & ~(8'd1 << r_idx);
  end

  hex_to_seg u_hex_to_seg (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      r_slotCnt  <= '0;
      r_idx      <= '0;
      r_frameVal <= '0;
      r_frameDot <= '0;
      r_digit    <= DIGIT_OFF;
      r_segment  <= SEG_BLANK;
    end else begin
      if (r_slotCnt == SLOT_LAST) begin
        r_slotCnt <= '0;
        r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
        r_slotCnt <= r_slotCnt + CW'(1);
      end

      // Frame registers only load at the start of slot 0, so a digit never tears
      if (r_slotCnt == '0 && r_idx == '0) begin
        r_frameVal <= disp.dispVal;
        r_frameDot <= disp.swit;
      end

      if (w_phase == PH_BLANK) begin
        r_digit   <= DIGIT_OFF;
        r_segment <= SEG_BLANK;
      end else begin
        r_digit   <= w_digitOn;
        r_segment <= {w_glyph, ~r_frameDot[r_idx]};
      end
    end
  end

  assign disp.digit   = r_digit;
  assign disp.segment = r_segment;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomised scoreboard bench for display_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_display_scan_driver;

  localparam int unsigned R     = 8;
  localparam int unsigned B     = 2;
  localparam int unsigned FRAME = 4 * R;

  logic clk;
  logic rst;

  display_scan_driver_if bus ();

  display_scan_driver #(
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk5  (clk),
    .reset (rst),
    .disp  (bus)
  );

  int unsigned vecs;
  int unsigned errs;
  int unsigned p;
  logic [15:0] mv;
  logic [3:0]  md;
  logic [15:0] expq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  // One cycle of stimulus: drive inputs, then predict the outputs after the next edge
  task automatic step(input logic [15:0] v, input logic [3:0] s);
    int unsigned pos;
    int unsigned k;
    logic [3:0]  nib;
    logic [7:0]  dig;
    @(negedge clk);
    bus.dispVal = v;
    bus.swit    = s;
    pos = p % R;
    k   = (p / R) % 4;
    if (p % FRAME == 0) begin
      mv = v;
      md = s;
    end
    if (pos < B) begin
      expq.push_back(16'hFFFF);
    end else begin
      nib = mv[4*k +: 4];
      dig = 8'hFF ^ (8'd1 << k);
      expq.push_back({dig, glyph(nib), ~md[k]});
    end
    p++;
  endtask

  task automatic check_dark(input string name);
    vecs++;
    if (bus.digit !== 8'hFF || bus.segment !== 8'hFF) begin
      errs++;
      $display("FAIL %s: digit=%h segment=%h, required FF/FF", name, bus.digit, bus.segment);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_dark("async_reset_dark");
    @(posedge clk);
    #2;
    rst = 1'b0;
    p = 0;
  endtask

  // Monitor: pops one prediction per edge and checks the one-hot-low digit rule
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        vecs++;
        if ({bus.digit, bus.segment} !== e) begin
          errs++;
          $display("FAIL scan t=%0t: digit=%h segment=%b, required digit=%h segment=%b",
                   $time, bus.digit, bus.segment, e[15:8], e[7:0]);
        end
        vecs++;
        if (bus.digit[7:4] !== 4'hF || $countones(~bus.digit) > 1) begin
          errs++;
          $display("FAIL digit_onehot t=%0t: digit=%h, required <=1 low bit in [3:0]",
                   $time, bus.digit);
        end
      end
    end
  end

  initial begin
    vecs = 0;
    errs = 0;
    p    = 0;
    mv   = '0;
    md   = '0;
    rst  = 1'b1;
    bus.dispVal = 16'h1234;
    bus.swit    = 4'h0;
    repeat (2) @(negedge clk);
    check_dark("reset_state");
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int f = 0; f < 2; f++)
      for (int j = 0; j < int'(FRAME); j++) step(16'h1234, 4'h0);

    for (int f = 0; f < 2; f++)
      for (int j = 0; j < int'(FRAME); j++) step(16'hABCD, 4'b0101);

    // Mid-frame change during slot 1 must wait for the next frame
    for (int j = 0; j < int'(FRAME); j++)
      step((j < int'(R) + 3) ? 16'h0000 : 16'hFFFF, 4'h0);
    for (int j = 0; j < int'(FRAME); j++) step(16'hFFFF, 4'h0);

    begin
      logic [15:0] rv;
      logic [3:0]  rs;
      rv = 16'($urandom);
      rs = 4'($urandom);
      for (int j = 0; j < 8 * int'(FRAME); j++) begin
        if ($urandom_range(3) == 0) begin
          rv = 16'($urandom);
          rs = 4'($urandom);
        end
        step(rv, rs);
      end
    end

    // Reset while idx=2, slotCnt=5
    while (p % FRAME != 2 * R + 5) step(16'($urandom), 4'($urandom));
    do_reset();

    for (int f = 0; f < 16; f++) begin
      logic [15:0] fv;
      logic [3:0]  fs;
      fv = {12'($urandom), 4'(f)};
      fs = 4'($urandom);
      for (int j = 0; j < int'(FRAME); j++)
        step((j == 0) ? fv : 16'($urandom), (j == 0) ? fs : 4'($urandom));
    end

    @(posedge clk);
    #2;
    vecs++;
    if (expq.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d predictions left, required 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
